// File: rtl/ethsniff_pkg.sv
// Shared types for the sniffer's match-record path: arbiter FSM states,
// grant encoding and the default record width.
package ethsniff_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ      = 2'd2,
        READ_WAIT = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    localparam int DEFAULT_REC_W = 32;

endpackage

// File: rtl/match_mem_arbiter_if.sv
// Bus bundle between the match-record requesters, the arbiter and the SRAM.
//
// Handshake rules: a requester raises wr_req/rd_req and holds it, along with
// wr_data/rd_addr, until the one-cycle wr_ack/rd_valid completes the
// transfer. It drops the request on the edge ending that completion cycle.
// A request still high when the arbiter is back in IDLE counts as new.
// rd_data is meaningful only while rd_valid is high. mem_rdata returns the
// word addressed one cycle after mem_re.
interface match_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  wr_req, wr_data, rd_req, rd_addr, mem_rdata,
        output wr_ack, rd_data, rd_valid, mem_addr, mem_wdata, mem_we, mem_re
    );

    // Requester / SRAM side
    modport master (
        output wr_req, wr_data, rd_req, rd_addr, mem_rdata,
        input  wr_ack, rd_data, rd_valid, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/match_log_ptr.sv
// Circular log bookkeeping for the match-record memory: write pointer,
// record count, oldest-record pointer and sticky overflow.
// MEM_ARB_OVERWRITE_EN: when defined, a write to a full log replaces the
// oldest record and the pointer keeps advancing; otherwise it is dropped.
module match_log_ptr #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_commit,
    input  logic              clear_log,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] oldest_ptr,
    output logic              overflow,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    assign full = (count == DEPTH);

    // When full the low bits of count are zero, so oldest tracks wr_ptr.
    assign oldest_ptr = wr_ptr - count[ADDR_W-1:0];

    // Pointer/count/overflow update; clear_log beats a coincident commit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear_log) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (wr_commit) begin
            if (!full) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end else begin
                overflow <= 1'b1;
`ifdef MEM_ARB_OVERWRITE_EN
                wr_ptr   <= wr_ptr + 1'b1;
`else
                wr_ptr   <= wr_ptr;
`endif
            end
        end
    end

endmodule

// File: rtl/match_mem_arbiter.sv
// Round-robin arbiter for the single-port match-record SRAM, shared by the
// capture write path and the host read path. Control outputs are registered
// from the next state so the SRAM sees clean, glitch-free strobes.
// MEM_ARB_OVERWRITE_EN: when defined, writes to a full log overwrite the
// oldest record; otherwise they are acked and dropped.
module match_mem_arbiter
    import ethsniff_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = DEFAULT_REC_W
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear_log,
    match_mem_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]     wr_ptr,
    output logic [ADDR_W:0]       count,
    output logic [ADDR_W-1:0]     oldest_ptr,
    output logic                  overflow,
    output arb_state_t            state_dbg
);

`ifdef MEM_ARB_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    arb_state_t state;
    arb_state_t next_state;
    grant_t     last_grant;
    logic       full;
    logic       full_after;
    logic [ADDR_W-1:0] ptr_after;

    assign state_dbg = state;

    match_log_ptr #(.ADDR_W(ADDR_W)) u_log_ptr (
        .clk        (clk),
        .n_rst      (n_rst),
        .wr_commit  (state == WRITE),
        .clear_log  (clear_log),
        .wr_ptr     (wr_ptr),
        .count      (count),
        .oldest_ptr (oldest_ptr),
        .overflow   (overflow),
        .full       (full)
    );

    // Log view as it will stand during a WRITE entered on this edge. Entry
    // is only from IDLE, where no commit is pending, so clear_log is the
    // only thing that can change it.
    always_comb begin
        full_after = full;
        ptr_after  = wr_ptr;
        if (clear_log) begin
            full_after = 1'b0;
            ptr_after  = '0;
        end
    end

    // Next-state decode; ties go to the side not granted last.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.wr_req && bus.rd_req)
                    next_state = (last_grant == GRANT_RD) ? WRITE : READ;
                else if (bus.wr_req)
                    next_state = WRITE;
                else if (bus.rd_req)
                    next_state = READ;
                else
                    next_state = IDLE;
            end
            WRITE:     next_state = IDLE;
            READ:      next_state = READ_WAIT;
            READ_WAIT: next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // State, grant history and registered SRAM/handshake strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            last_grant    <= GRANT_RD;
            bus.wr_ack    <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == WRITE)
                last_grant <= GRANT_WR;
            else if (state == IDLE && next_state == READ)
                last_grant <= GRANT_RD;
            bus.wr_ack   <= (next_state == WRITE);
            bus.mem_we   <= (next_state == WRITE) && (!full_after || OVERWRITE);
            bus.mem_re   <= (next_state == READ);
            bus.rd_valid <= (next_state == READ_WAIT);
            case (next_state)
                WRITE: begin
                    bus.mem_addr  <= ptr_after;
                    bus.mem_wdata <= bus.wr_data;
                end
                READ: begin
                    bus.mem_addr  <= bus.rd_addr;
                    bus.mem_wdata <= '0;
                end
                default: begin
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                end
            endcase
        end
    end

    // SRAM data is presented in the cycle after mem_re, i.e. READ_WAIT.
    assign bus.rd_data = (state == READ_WAIT) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_match_mem_arbiter.sv
// Bench for match_mem_arbiter with a 4-entry log. Honours
// MEM_ARB_OVERWRITE_EN for the full-log expectations.
module tb_match_mem_arbiter;
    import ethsniff_pkg::*;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int EW = AW + 1 + DW;
`ifdef MEM_ARB_OVERWRITE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic          clk;
    logic          n_rst;
    logic          clear_log;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW-1:0] oldest_ptr;
    logic          overflow;
    arb_state_t    state_dbg;

    match_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    match_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear_log  (clear_log),
        .bus        (bus),
        .wr_ptr     (wr_ptr),
        .count      (count),
        .oldest_ptr (oldest_ptr),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected write beats {addr, we, data} and read data, in issue order.
    logic [EW-1:0] wr_exp_q[$];
    logic [DW-1:0] rd_exp_q[$];

    // Bench view of the log.
    logic [AW-1:0] m_ptr;
    int            m_cnt;

    // SRAM model: one-cycle read latency.
    logic [DW-1:0] sram [4];
    always @(posedge clk) begin
        if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr];
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.wr_ack) begin
                total++;
                if (wr_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_wr_unexpected: got addr=%0d we=%0b data=%h, none expected",
                             bus.mem_addr, bus.mem_we, bus.mem_wdata);
                end else begin
                    logic [EW-1:0] e;
                    e = wr_exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== e) begin
                        bad++;
                        $display("FAIL sb_wr: got addr=%0d we=%0b data=%h, want addr=%0d we=%0b data=%h",
                                 bus.mem_addr, bus.mem_we, bus.mem_wdata,
                                 e[EW-1 -: AW], e[DW], e[DW-1:0]);
                    end
                end
            end
            if (bus.mem_we && !bus.wr_ack) begin
                total++;
                bad++;
                $display("FAIL sb_we_without_ack: mem_we=1 wr_ack=0, want no write");
            end
            if (bus.rd_valid) begin
                total++;
                if (rd_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_rd_unexpected: got rd_data=%h, none expected", bus.rd_data);
                end else begin
                    logic [DW-1:0] e;
                    e = rd_exp_q.pop_front();
                    if (bus.rd_data !== e) begin
                        bad++;
                        $display("FAIL sb_rd: got rd_data=%h want %h", bus.rd_data, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        n_rst       = 1'b0;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        clear_log   = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        m_ptr = '0;
        m_cnt = 0;
        @(negedge clk);
    endtask

    // Called at a negedge with the arbiter idle; returns at a negedge.
    task automatic do_write(input logic [DW-1:0] d);
        logic m_we;
        int   n;
        m_we = (m_cnt < 4) || OVR;
        wr_exp_q.push_back({m_ptr, m_we, d});
        if (m_cnt < 4) begin
            m_ptr = m_ptr + 1'b1;
            m_cnt = m_cnt + 1;
        end else if (OVR) begin
            m_ptr = m_ptr + 1'b1;
        end
        bus.wr_req  = 1'b1;
        bus.wr_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wr_ack && n < 10);
        total++;
        if (!bus.wr_ack) begin
            bad++;
            $display("FAIL write_timeout: wr_ack=%0b after %0d cycles, want 1", bus.wr_ack, n);
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst       = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        clear_log   = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        m_ptr = '0;
        m_cnt = 0;
        @(negedge clk);
        total++;
        if ({bus.wr_ack, bus.rd_valid, bus.mem_we, bus.mem_re, bus.mem_addr,
             bus.mem_wdata, bus.rd_data, wr_ptr, count, oldest_ptr, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%0b rv=%0b we=%0b re=%0b addr=%0d wd=%h rd=%h ptr=%0d cnt=%0d old=%0d ovf=%0b, want all 0",
                     bus.wr_ack, bus.rd_valid, bus.mem_we, bus.mem_re, bus.mem_addr,
                     bus.mem_wdata, bus.rd_data, wr_ptr, count, oldest_ptr, overflow);
        end
        total++;
        if (state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
        end
    endtask

    task automatic test_read();
        bus.rd_req  = 1'b1;
        bus.rd_addr = 2'd3;
        rd_exp_q.push_back(32'h12345678);
        @(negedge clk);
        total++;
        if ({bus.mem_re, bus.mem_addr, bus.rd_valid} !== {1'b1, 2'd3, 1'b0}) begin
            bad++;
            $display("FAIL read_issue: got re=%0b addr=%0d rv=%0b want re=1 addr=3 rv=0",
                     bus.mem_re, bus.mem_addr, bus.rd_valid);
        end
        @(negedge clk);
        total++;
        if ({bus.rd_valid, bus.mem_re} !== 2'b10) begin
            bad++;
            $display("FAIL read_valid: got rv=%0b re=%0b want rv=1 re=0", bus.rd_valid, bus.mem_re);
        end
        bus.rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        bus.wr_req  = 1'b1;
        bus.wr_data = 32'hDEADBEEF;
        wr_exp_q.push_back({2'd0, 1'b1, 32'hDEADBEEF});
        m_ptr = 2'd1;
        m_cnt = 1;
        @(negedge clk);
        total++;
        if ({bus.wr_ack, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL write_strobe: got ack=%0b we=%0b addr=%0d want ack=1 we=1 addr=0",
                     bus.wr_ack, bus.mem_we, bus.mem_addr);
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        total++;
        if ({wr_ptr, count, bus.wr_ack} !== {2'd1, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL write_log: got ptr=%0d cnt=%0d ack=%0b want ptr=1 cnt=1 ack=0",
                     wr_ptr, count, bus.wr_ack);
        end
    endtask

    task automatic test_reset_mid_read();
        bus.rd_req  = 1'b1;
        bus.rd_addr = 2'd3;
        @(negedge clk);
        total++;
        if (bus.mem_re !== 1'b1) begin
            bad++;
            $display("FAIL midread_setup: got mem_re=%0b want 1", bus.mem_re);
        end
        n_rst = 1'b0;
        #1;
        total++;
        if ({bus.wr_ack, bus.rd_valid, bus.mem_we, bus.mem_re, bus.mem_addr,
             bus.mem_wdata, bus.rd_data, wr_ptr, count, oldest_ptr, overflow} !== '0) begin
            bad++;
            $display("FAIL midread_outputs: ack=%0b rv=%0b we=%0b re=%0b addr=%0d ptr=%0d cnt=%0d, want all 0",
                     bus.wr_ack, bus.rd_valid, bus.mem_we, bus.mem_re, bus.mem_addr,
                     wr_ptr, count);
        end
        total++;
        if (state_dbg !== IDLE) begin
            bad++;
            $display("FAIL midread_state: got %0d want %0d", state_dbg, IDLE);
        end
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        m_ptr = '0;
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL midread_no_valid: cycle %0d rd_valid=%0b want 0", i, bus.rd_valid);
            end
        end
    endtask

    task automatic test_fairness();
        logic [7:0] seq [4];
        int         n_g;
        logic [DW-1:0] d;
        d = 32'hA5A50000 | 32'($urandom_range(0, 16'hFFFF));
        wr_exp_q.push_back({2'd0, 1'b1, d});
        wr_exp_q.push_back({2'd1, 1'b1, d});
        rd_exp_q.push_back(32'h12345678);
        rd_exp_q.push_back(32'h12345678);
        n_g = 0;
        bus.wr_req  = 1'b1;
        bus.wr_data = d;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 2'd3;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.wr_ack && n_g < 4) begin seq[n_g] = "W"; n_g++; end
            if (bus.mem_re && n_g < 4) begin seq[n_g] = "R"; n_g++; end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        m_ptr = 2'd2;
        m_cnt = 2;
        total++;
        if (n_g != 4 || {seq[0], seq[1], seq[2], seq[3]} !== "WRWR") begin
            bad++;
            $display("FAIL fairness_order: got %0d grants %s%s%s%s want WRWR",
                     n_g, seq[0], seq[1], seq[2], seq[3]);
        end
        @(negedge clk);
        total++;
        if ({wr_ptr, count} !== {2'd2, 3'd2}) begin
            bad++;
            $display("FAIL fairness_log: got ptr=%0d cnt=%0d want ptr=2 cnt=2", wr_ptr, count);
        end
    endtask

    task automatic test_full();
        logic [AW-1:0] exp_ptr;
        apply_reset();
        for (int i = 0; i < 4; i++) do_write($urandom);
        total++;
        if ({count, wr_ptr, overflow} !== {3'd4, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL full_four: got cnt=%0d ptr=%0d ovf=%0b want cnt=4 ptr=0 ovf=0",
                     count, wr_ptr, overflow);
        end
        do_write($urandom);
        exp_ptr = OVR ? 2'd1 : 2'd0;
        total++;
        if ({count, wr_ptr, overflow} !== {3'd4, exp_ptr, 1'b1}) begin
            bad++;
            $display("FAIL full_fifth: got cnt=%0d ptr=%0d ovf=%0b want cnt=4 ptr=%0d ovf=1",
                     count, wr_ptr, overflow, exp_ptr);
        end
        total++;
        if (oldest_ptr !== exp_ptr) begin
            bad++;
            $display("FAIL full_oldest: got %0d want %0d", oldest_ptr, exp_ptr);
        end
    endtask

    task automatic test_clear();
        logic [DW-1:0] d;
        // Standalone pulse on a full, overflowed log.
        clear_log = 1'b1;
        @(negedge clk);
        clear_log = 1'b0;
        m_ptr = '0;
        m_cnt = 0;
        total++;
        if ({wr_ptr, count, overflow} !== {2'd0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL clear_pulse: got ptr=%0d cnt=%0d ovf=%0b want 0 0 0",
                     wr_ptr, count, overflow);
        end
        for (int i = 0; i < 3; i++) do_write($urandom);
        total++;
        if ({wr_ptr, count} !== {2'd3, 3'd3}) begin
            bad++;
            $display("FAIL clear_pre: got ptr=%0d cnt=%0d want ptr=3 cnt=3", wr_ptr, count);
        end
        // Fourth write with clear_log landing in its WRITE cycle.
        d = $urandom;
        wr_exp_q.push_back({2'd3, 1'b1, d});
        bus.wr_req  = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        total++;
        if (bus.wr_ack !== 1'b1) begin
            bad++;
            $display("FAIL clear_coinc_ack: got wr_ack=%0b want 1", bus.wr_ack);
        end
        clear_log  = 1'b1;
        bus.wr_req = 1'b0;
        @(negedge clk);
        clear_log = 1'b0;
        m_ptr = '0;
        m_cnt = 0;
        total++;
        if ({wr_ptr, count, overflow, oldest_ptr} !== {2'd0, 3'd0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL clear_coinc_log: got ptr=%0d cnt=%0d ovf=%0b old=%0d want 0 0 0 0",
                     wr_ptr, count, overflow, oldest_ptr);
        end
        total++;
        if (sram[3] !== d) begin
            bad++;
            $display("FAIL clear_coinc_sram: got sram[3]=%h want %h", sram[3], d);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        sram[0] = '0;
        sram[1] = '0;
        sram[2] = '0;
        sram[3] = 32'h12345678;
        test_reset();
        test_read();
        test_single_write();
        test_reset_mid_read();
        test_fairness();
        test_full();
        test_clear();
        repeat (3) @(negedge clk);
        total++;
        if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d writes %0d reads outstanding want 0 0",
                     wr_exp_q.size(), rd_exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait above never resolves.
    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
